// File: rtl/wb_pipe_unit_pkg.sv
// Shared constants for the writeback pipe unit: source selects, FSM states, x0.
package wb_pipe_unit_pkg;

    localparam int unsigned WB_ALU     = 0;
    localparam int unsigned WB_LU      = 1;
    localparam int unsigned WB_IMM     = 2;
    localparam int unsigned WB_IADDER  = 3;
    localparam int unsigned WB_CSR     = 4;
    localparam int unsigned WB_PC_PLUS = 5;

    localparam logic [4:0] X0 = 5'd0;

    typedef enum logic {
        RUN     = 1'b0,
        WAIT_LU = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_pipe_unit_if.sv
// Bus bundle between the execute/memory stage and the writeback pipe unit.
interface wb_pipe_unit_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_SRC = 6,
    parameter int unsigned SEL_W   = 3
);
    logic                    valid_in;
    logic                    ready_out;
    logic [SEL_W-1:0]        wb_sel_in;
    logic [NUM_SRC*XLEN-1:0] src_bus_in;
    logic [4:0]              rd_addr_in;
    logic                    rf_wr_en_in;
    logic                    lu_valid_in;
    logic [XLEN-1:0]         lu_data_in;
    logic                    flush_in;
    logic                    alu_src_in;
    logic [XLEN-1:0]         rs2_in;
    logic [XLEN-1:0]         imm_in;
    logic [XLEN-1:0]         alu_2nd_src_out;
    logic                    wb_valid_out;
    logic [XLEN-1:0]         wb_data_out;
    logic [4:0]              rd_addr_out;
    logic                    rf_wr_en_out;
    logic                    stall_out;
    logic                    lu_timeout_out;
    logic                    bad_sel_out;

    modport master (
        output valid_in, wb_sel_in, src_bus_in, rd_addr_in, rf_wr_en_in, lu_valid_in,
               lu_data_in, flush_in, alu_src_in, rs2_in, imm_in,
        input  ready_out, alu_2nd_src_out, wb_valid_out, wb_data_out, rd_addr_out,
               rf_wr_en_out, stall_out, lu_timeout_out, bad_sel_out
    );

    modport slave (
        input  valid_in, wb_sel_in, src_bus_in, rd_addr_in, rf_wr_en_in, lu_valid_in,
               lu_data_in, flush_in, alu_src_in, rs2_in, imm_in,
        output ready_out, alu_2nd_src_out, wb_valid_out, wb_data_out, rd_addr_out,
               rf_wr_en_out, stall_out, lu_timeout_out, bad_sel_out
    );

endinterface

// File: rtl/wb_pipe_unit_src_mux.sv
// NUM_SRC:1 writeback source mux; out-of-range selects fall back to source 0.
module wb_src_mux #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_SRC = 6,
    parameter int unsigned SEL_W   = 3
) (
    input  logic [SEL_W-1:0]        i_sel,
    input  logic [NUM_SRC*XLEN-1:0] i_src_bus,
    output logic [XLEN-1:0]         o_data,
    output logic                    o_bad_sel
);

    always_comb begin
        o_data    = i_src_bus[0 +: XLEN];
        o_bad_sel = 1'b1;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (i_sel == SEL_W'(k)) begin
                o_data    = i_src_bus[k*XLEN +: XLEN];
                o_bad_sel = 1'b0;
            end
        end
    end

endmodule

// File: rtl/wb_pipe_unit.sv
// One-cycle writeback stage with valid/ready, load-wait FSM, load timeout and flush.
module wb_pipe_unit
    import wb_pipe_unit_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NUM_SRC    = 6,
    parameter int unsigned SEL_W      = 3,
    parameter int unsigned LU_TIMEOUT = 16,
    parameter int unsigned CNT_W      = 5
) (
    input logic           clk_in,
    input logic           rst_n_in,
    wb_pipe_unit_if.slave bus
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'((LU_TIMEOUT == 0) ? 0 : LU_TIMEOUT - 1);

    wb_state_e        r_state, w_state_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic [4:0]       r_hold_rd, w_hold_rd_d;
    logic             r_hold_we, w_hold_we_d;
    logic             r_wb_valid, w_wb_valid_d;
    logic [XLEN-1:0]  r_wb_data, w_wb_data_d;
    logic [4:0]       r_rd, w_rd_d;
    logic             r_we, w_we_d;
    logic             r_timeout, w_timeout_d;
    logic             r_bad_sel, w_bad_sel_d;

    logic [XLEN-1:0]  w_mux_data;
    logic             w_mux_bad;
    logic             w_accept;
    logic             w_is_lu;

    wb_src_mux #(
        .XLEN    (XLEN),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_src_mux (
        .i_sel     (bus.wb_sel_in),
        .i_src_bus (bus.src_bus_in),
        .o_data    (w_mux_data),
        .o_bad_sel (w_mux_bad)
    );

    assign w_accept = bus.valid_in & (r_state == RUN) & ~bus.flush_in;
    assign w_is_lu  = (bus.wb_sel_in == SEL_W'(WB_LU));

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_hold_rd_d  = r_hold_rd;
        w_hold_we_d  = r_hold_we;
        w_wb_valid_d = 1'b0;
        w_wb_data_d  = r_wb_data;
        w_rd_d       = r_rd;
        w_we_d       = 1'b0;
        w_timeout_d  = 1'b0;
        w_bad_sel_d  = 1'b0;
        unique case (r_state)
            RUN: begin
                if (w_accept) begin
                    if (w_is_lu && !bus.lu_valid_in) begin
                        w_state_d   = WAIT_LU;
                        w_cnt_d     = '0;
                        w_hold_rd_d = bus.rd_addr_in;
                        w_hold_we_d = bus.rf_wr_en_in & (bus.rd_addr_in != X0);
                    end else begin
                        w_wb_valid_d = 1'b1;
                        w_wb_data_d  = w_is_lu ? bus.lu_data_in : w_mux_data;
                        w_rd_d       = bus.rd_addr_in;
                        w_we_d       = bus.rf_wr_en_in & (bus.rd_addr_in != X0);
                        w_bad_sel_d  = w_mux_bad;
                    end
                end
            end
            WAIT_LU: begin
                // Flush beats load data, which beats the timeout.
                if (bus.flush_in) begin
                    w_state_d = RUN;
                end else if (bus.lu_valid_in) begin
                    w_state_d    = RUN;
                    w_wb_valid_d = 1'b1;
                    w_wb_data_d  = bus.lu_data_in;
                    w_rd_d       = r_hold_rd;
                    w_we_d       = r_hold_we;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                    if ((LU_TIMEOUT != 0) && (r_cnt == LastCnt)) begin
                        w_state_d    = RUN;
                        w_wb_valid_d = 1'b1;
                        w_wb_data_d  = '0;
                        w_rd_d       = r_hold_rd;
                        w_timeout_d  = 1'b1;
                    end
                end
            end
            default: w_state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state    <= RUN;
            r_cnt      <= '0;
            r_hold_rd  <= '0;
            r_hold_we  <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_data  <= '0;
            r_rd       <= '0;
            r_we       <= 1'b0;
            r_timeout  <= 1'b0;
            r_bad_sel  <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_hold_rd  <= w_hold_rd_d;
            r_hold_we  <= w_hold_we_d;
            r_wb_valid <= w_wb_valid_d;
            r_wb_data  <= w_wb_data_d;
            r_rd       <= w_rd_d;
            r_we       <= w_we_d;
            r_timeout  <= w_timeout_d;
            r_bad_sel  <= w_bad_sel_d;
        end
    end

    assign bus.ready_out       = (r_state == RUN);
    assign bus.stall_out       = (r_state == WAIT_LU);
    assign bus.alu_2nd_src_out = bus.alu_src_in ? bus.rs2_in : bus.imm_in;
    assign bus.wb_valid_out    = r_wb_valid;
    assign bus.wb_data_out     = r_wb_data;
    assign bus.rd_addr_out     = r_rd;
    assign bus.rf_wr_en_out    = r_we;
    assign bus.lu_timeout_out  = r_timeout;
    assign bus.bad_sel_out     = r_bad_sel;

endmodule

// File: tb/tb_wb_pipe_unit.sv
// Directed bench for wb_pipe_unit: vector table for single-cycle commits plus load/flush/reset sequences.
module tb_wb_pipe_unit;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    wb_pipe_unit_if #(.XLEN(32), .NUM_SRC(6), .SEL_W(3)) bus ();

    wb_pipe_unit #(
        .XLEN       (32),
        .NUM_SRC    (6),
        .SEL_W      (3),
        .LU_TIMEOUT (4),
        .CNT_W      (5)
    ) u_dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;
        logic [4:0]  rd;
        logic        we;
        logic        luv;
        logic [31:0] lud;
        logic        alu_src;
        logic [31:0] exp_data;
        logic        exp_we;
        logic        exp_bad;
        logic [31:0] exp_alu;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_load(input logic [4:0] rd);
        bus.valid_in    = 1'b1;
        bus.wb_sel_in   = 3'd1;
        bus.rd_addr_in  = rd;
        bus.rf_wr_en_in = 1'b1;
        bus.lu_valid_in = 1'b0;
        step();
        bus.valid_in = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        bus.valid_in    = 1'b0;
        bus.wb_sel_in   = '0;
        bus.src_bus_in  = {32'h5555_5555, 32'h4444_4444, 32'h3333_3333,
                           32'h2222_2222, 32'h1111_1111, 32'h0000_1234};
        bus.rd_addr_in  = '0;
        bus.rf_wr_en_in = 1'b0;
        bus.lu_valid_in = 1'b0;
        bus.lu_data_in  = '0;
        bus.flush_in    = 1'b0;
        bus.alu_src_in  = 1'b0;
        bus.rs2_in      = 32'h0000_ABCD;
        bus.imm_in      = 32'hFFFF_FFF0;

        vecs[0] = '{3'd0, 5'd5,  1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_1234, 1'b1, 1'b0, 32'h0000_ABCD};
        vecs[1] = '{3'd2, 5'd3,  1'b1, 1'b0, 32'h0,         1'b0, 32'h2222_2222, 1'b1, 1'b0, 32'hFFFF_FFF0};
        vecs[2] = '{3'd5, 5'd31, 1'b0, 1'b0, 32'h0,         1'b1, 32'h5555_5555, 1'b0, 1'b0, 32'h0000_ABCD};
        vecs[3] = '{3'd0, 5'd0,  1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_1234, 1'b0, 1'b0, 32'hFFFF_FFF0};
        vecs[4] = '{3'd7, 5'd9,  1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_1234, 1'b1, 1'b1, 32'h0000_ABCD};
        vecs[5] = '{3'd6, 5'd10, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_1234, 1'b1, 1'b1, 32'hFFFF_FFF0};
        vecs[6] = '{3'd1, 5'd12, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0000_ABCD};
        vecs[7] = '{3'd4, 5'd1,  1'b1, 1'b0, 32'h0,         1'b0, 32'h4444_4444, 1'b1, 1'b0, 32'hFFFF_FFF0};
        vecs[8] = '{3'd3, 5'd2,  1'b1, 1'b0, 32'h0,         1'b1, 32'h3333_3333, 1'b1, 1'b0, 32'h0000_ABCD};

        #12;
        chk("reset wb_valid", bus.wb_valid_out, 1'b0);
        chk("reset wb_data", bus.wb_data_out, 32'h0);
        chk("reset rd_addr", bus.rd_addr_out, 5'd0);
        chk("reset rf_wr_en", bus.rf_wr_en_out, 1'b0);
        chk("reset ready", bus.ready_out, 1'b1);
        chk("reset stall", bus.stall_out, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Back-to-back single-cycle commits
        for (int i = 0; i < 9; i++) begin
            bus.valid_in    = 1'b1;
            bus.wb_sel_in   = vecs[i].sel;
            bus.rd_addr_in  = vecs[i].rd;
            bus.rf_wr_en_in = vecs[i].we;
            bus.lu_valid_in = vecs[i].luv;
            bus.lu_data_in  = vecs[i].lud;
            bus.alu_src_in  = vecs[i].alu_src;
            #1;
            chk($sformatf("vec%0d alu_2nd", i), bus.alu_2nd_src_out, vecs[i].exp_alu);
            step();
            chk($sformatf("vec%0d wb_valid", i), bus.wb_valid_out, 1'b1);
            chk($sformatf("vec%0d wb_data", i), bus.wb_data_out, vecs[i].exp_data);
            chk($sformatf("vec%0d rd_addr", i), bus.rd_addr_out, vecs[i].rd);
            chk($sformatf("vec%0d rf_wr_en", i), bus.rf_wr_en_out, vecs[i].exp_we);
            chk($sformatf("vec%0d bad_sel", i), bus.bad_sel_out, vecs[i].exp_bad);
            chk($sformatf("vec%0d ready", i), bus.ready_out, 1'b1);
        end
        bus.valid_in    = 1'b0;
        bus.lu_valid_in = 1'b0;
        step();
        chk("idle wb_valid", bus.wb_valid_out, 1'b0);
        chk("idle wb_data held", bus.wb_data_out, 32'h3333_3333);
        chk("idle rd held", bus.rd_addr_out, 5'd2);
        chk("idle rf_wr_en", bus.rf_wr_en_out, 1'b0);

        // Load wait: three stall cycles, then data arrives; valid_in during stall is ignored
        accept_load(5'd7);
        bus.valid_in   = 1'b1;
        bus.wb_sel_in  = 3'd2;
        bus.rd_addr_in = 5'd4;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("lw stall c%0d", i), bus.stall_out, 1'b1);
            chk($sformatf("lw ready c%0d", i), bus.ready_out, 1'b0);
            chk($sformatf("lw wb_valid c%0d", i), bus.wb_valid_out, 1'b0);
            if (i == 2) begin
                bus.lu_valid_in = 1'b1;
                bus.lu_data_in  = 32'h0000_CAFE;
            end
            step();
        end
        bus.valid_in    = 1'b0;
        bus.lu_valid_in = 1'b0;
        chk("lw wb_valid", bus.wb_valid_out, 1'b1);
        chk("lw wb_data", bus.wb_data_out, 32'h0000_CAFE);
        chk("lw rd_addr", bus.rd_addr_out, 5'd7);
        chk("lw rf_wr_en", bus.rf_wr_en_out, 1'b1);
        chk("lw ready", bus.ready_out, 1'b1);
        chk("lw timeout", bus.lu_timeout_out, 1'b0);

        // Timeout with LU_TIMEOUT=4: pulse on the fourth edge after the accept edge
        accept_load(5'd8);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to stall c%0d", i), bus.stall_out, 1'b1);
            chk($sformatf("to pulse c%0d", i), bus.lu_timeout_out, 1'b0);
            step();
        end
        chk("to pulse", bus.lu_timeout_out, 1'b1);
        chk("to wb_valid", bus.wb_valid_out, 1'b1);
        chk("to wb_data", bus.wb_data_out, 32'h0);
        chk("to rf_wr_en", bus.rf_wr_en_out, 1'b0);
        chk("to ready", bus.ready_out, 1'b1);
        step();
        chk("to pulse cleared", bus.lu_timeout_out, 1'b0);
        chk("to wb_valid cleared", bus.wb_valid_out, 1'b0);

        // Flush beats lu_valid_in while waiting
        accept_load(5'd9);
        bus.flush_in    = 1'b1;
        bus.lu_valid_in = 1'b1;
        bus.lu_data_in  = 32'h0000_BEEF;
        step();
        bus.flush_in    = 1'b0;
        bus.lu_valid_in = 1'b0;
        chk("fl wb_valid", bus.wb_valid_out, 1'b0);
        chk("fl timeout", bus.lu_timeout_out, 1'b0);
        chk("fl ready", bus.ready_out, 1'b1);
        chk("fl wb_data held", bus.wb_data_out, 32'h0);

        // Flush in RUN blocks the accept; stray lu_valid_in in RUN is ignored
        bus.valid_in   = 1'b1;
        bus.wb_sel_in  = 3'd0;
        bus.rd_addr_in = 5'd3;
        bus.flush_in   = 1'b1;
        step();
        chk("flrun wb_valid", bus.wb_valid_out, 1'b0);
        bus.valid_in    = 1'b0;
        bus.flush_in    = 1'b0;
        bus.lu_valid_in = 1'b1;
        step();
        bus.lu_valid_in = 1'b0;
        chk("luv idle wb_valid", bus.wb_valid_out, 1'b0);
        chk("luv idle stall", bus.stall_out, 1'b0);

        // Async reset mid-wait abandons the load
        bus.valid_in    = 1'b1;
        bus.wb_sel_in   = 3'd2;
        bus.rd_addr_in  = 5'd6;
        bus.rf_wr_en_in = 1'b1;
        step();
        accept_load(5'd11);
        chk("rs wait data held", bus.wb_data_out, 32'h2222_2222);
        chk("rs wait stall", bus.stall_out, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs wb_data", bus.wb_data_out, 32'h0);
        chk("rs rd_addr", bus.rd_addr_out, 5'd0);
        chk("rs stall", bus.stall_out, 1'b0);
        chk("rs ready", bus.ready_out, 1'b1);
        @(negedge clk);
        rst_n           = 1'b1;
        bus.lu_valid_in = 1'b1;
        bus.lu_data_in  = 32'h0000_0001;
        step();
        chk("rs late lu wb_valid", bus.wb_valid_out, 1'b0);
        chk("rs late lu rf_wr_en", bus.rf_wr_en_out, 1'b0);
        bus.lu_valid_in = 1'b0;
        step();
        chk("rs late lu wb_valid2", bus.wb_valid_out, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
